// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: first-word-fall-through
// byte FIFO with sticky overflow/framing status and an error counter.
module uart_rx_fifo #(
   parameter int Depth = 16,
   localparam int CW = $clog2(Depth) + 1
) (
   input  logic          clk,
   input  logic          nReset,
   input  logic [7:0]    rx_data,
   input  logic          rx_done,
   input  logic          rx_err,
   output logic [7:0]    out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] count,
   output logic          overflow,
   output logic          frame_err,
   output logic [7:0]    err_count,
   input  logic          clr_status,
   input  logic          flush
);

   localparam int AW = CW - 1;

   if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_depth_chk
      $error("uart_rx_fifo: Depth must be a power of 2 and >= 2");
   end

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_pend_q, wr_pend_d;
   logic          overflow_q, overflow_d;
   logic          frame_err_q, frame_err_d;
   logic [7:0]    err_count_q, err_count_d;
   logic [7:0]    mem_q [Depth];

   logic pop;
   logic full;
   logic push_ok;
   logic drop;
   logic mem_we;

   always_comb begin
      pop     = (count_q != '0) && out_ready;
      full    = (count_q == CW'(Depth));
      push_ok = wr_pend_q && (!full || pop);
      drop    = wr_pend_q && full && !pop && !flush;
      mem_we  = push_ok && !flush;

      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      wr_pend_d = rx_done;

      if (flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         wr_pend_d = 1'b0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
         if (push_ok && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push_ok) count_d = count_q - 1'b1;
      end
   end

   // A status event coinciding with clr_status survives the clear
   always_comb begin
      overflow_d  = (clr_status ? 1'b0 : overflow_q) | drop;
      frame_err_d = (clr_status ? 1'b0 : frame_err_q) | rx_err;
      err_count_d = err_count_q;
      if (clr_status)
         err_count_d = {7'b0, rx_err};
      else if (rx_err && err_count_q != 8'hFF)
         err_count_d = err_count_q + 8'd1;
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         wr_pend_q   <= 1'b0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         wr_pend_q   <= wr_pend_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
         err_count_q <= err_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= rx_data;
   end

   always_comb begin
      out_valid = (count_q != '0);
      out_data  = out_valid ? mem_q[rd_ptr_q] : 8'd0;
      count     = count_q;
      overflow  = overflow_q;
      frame_err = frame_err_q;
      err_count = err_count_q;
   end

endmodule
